apb_gpio_slave: RTL and testbench
=================================

APB_GPIO_SLAVE -- requirements
Module: apb_gpio_slave

Interface
REQ-001 The block SHALL have parameter N_GPIO, default 8, range 1..32: number of GPIO pins.
REQ-002 The block SHALL have port PCLK  input  1  APB clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port PRESET  input  1  reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port PADDR  input  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
REQ-005 The block SHALL have ports PSEL, PENABLE and PWRITE, each input  1, with standard APB meanings.
REQ-006 The block SHALL have port PWDATA  input  32  write data.
REQ-007 The block SHALL have port PSTRB  input  4  byte-lane write enables.
REQ-008 The block SHALL have port PRDATA  output  32  read data.
REQ-009 The block SHALL have ports PREADY and PSLVERR, each output  1: transfer complete and transfer error.
REQ-010 The block SHALL have port gpio_in  input  N_GPIO  asynchronous pin inputs.
REQ-011 The block SHALL have port gpio_out  output  N_GPIO  driven output values.
REQ-012 The block SHALL have port gpio_oe  output  N_GPIO  output enables (1 = drive).
REQ-013 The block SHALL have port irq  output  1  level interrupt; present only when GPIO_IRQ_EN is defined.

Function
REQ-014 Register map SHALL be: 0x00 MODER (RW, bit=1 output), 0x04 ODR (RW), 0x08 IDR (RO), 0x0C IER (RW), 0x10 ISR (RW1C); all registers are N_GPIO bits wide and upper bits read 0.
REQ-015 The APB FSM SHALL have two states: IDLE and ACK.
REQ-016 IDLE SHALL go to ACK when PSEL=1 and PENABLE=1; it SHALL stay in IDLE otherwise.
REQ-017 ACK SHALL go to IDLE unconditionally.
REQ-018 PREADY SHALL be 0 in IDLE and 1 in ACK, giving exactly one wait state per access.
REQ-019 Register writes SHALL commit on the PCLK edge that ends ACK, and only when PWRITE=1.
REQ-020 Register writes SHALL apply only to the byte lanes whose PSTRB bit is 1.
REQ-021 PRDATA SHALL be valid while PREADY=1 and SHALL be 0 at all other times.
REQ-022 PSLVERR SHALL be 1 in ACK for an address above 0x10 or a write to IDR; such accesses SHALL have no side effects.
REQ-023 gpio_in SHALL pass through a 2-flop synchronizer; IDR SHALL equal the synchronizer output, so a pin change is readable 2 PCLK edges later.
REQ-024 gpio_out SHALL equal ODR, and gpio_oe SHALL equal MODER, both registered with no added latency.
REQ-025 A rising edge on a synchronized input bit SHALL set the matching ISR bit when that IER bit is 1.
REQ-026 When an ISR set and a W1C clear hit the same bit on the same edge, the set SHALL win.
REQ-027 irq SHALL equal the OR-reduction of (ISR AND IER).
REQ-028 If PSEL drops during ACK, the access SHALL still complete in that cycle.

Reset
REQ-029 While PRESET=0 the block SHALL hold: state=IDLE, MODER=ODR=IER=ISR=0, synchronizer flops=0, PREADY=0, PSLVERR=0, PRDATA=0, irq=0.
REQ-030 Reset asserted mid-access SHALL abort the access with no register update.
REQ-031 After reset release the first access SHALL behave normally.

Configuration
REQ-032 With macro GPIO_IRQ_EN defined, IER, ISR, the edge detector and irq SHALL be implemented.
REQ-033 With GPIO_IRQ_EN undefined, addresses 0x0C and 0x10 SHALL read 0 and return PSLVERR=1, and port irq SHALL be absent.

Structure
REQ-034 Package gpio_pkg SHALL hold the register offset constants and the APB state enum (IDLE, ACK).
REQ-035 Sub-module gpio_sync SHALL hold the parameterized 2-flop synchronizer plus the delayed copy used for edge detection.

Verification
REQ-036 Scenario: write MODER=0x0F with PSTRB=0x1 -> PREADY low one cycle then high; gpio_oe=0x0F after the ACK edge; PSLVERR=0.
REQ-037 Scenario: write ODR=0xAA with PSTRB=0x0 -> ODR stays 0x00; then PSTRB=0x1 -> gpio_out=0xAA.
REQ-038 Scenario: drive gpio_in=0x5A -> IDR read 3 or more cycles later returns 0x0000005A; a write to 0x08 gives PSLVERR=1 and IDR unchanged.
REQ-039 Scenario (GPIO_IRQ_EN): IER=0x01, gpio_in[0] goes 0->1 -> ISR=0x01 and irq=1; writing ISR=0x01 clears both; an edge coinciding with the clear leaves ISR=0x01.
REQ-040 Scenario: read 0x1C -> PSLVERR=1 and PRDATA=0.
REQ-041 Scenario: assert PRESET during ACK -> all outputs 0; the next access completes normally.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO slave: register offsets, bus FSM states
// and the byte-strobe to bit-mask helper.
package gpio_pkg;

  typedef enum logic {
    StIdle,
    StAck
  } apb_state_e;

  localparam logic [4:0] OffModer = 5'h00;
  localparam logic [4:0] OffOdr   = 5'h04;
  localparam logic [4:0] OffIdr   = 5'h08;
  localparam logic [4:0] OffIer   = 5'h0C;
  localparam logic [4:0] OffIsr   = 5'h10;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop input synchronizer with a delayed copy of the synchronized value
// for rising-edge detection.
module gpio_sync #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] sync_o,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB GPIO slave with one wait state per access. Interrupt registers, edge
// detection and the irq port exist only when GPIO_IRQ_EN is defined.
module apb_gpio_slave
  import gpio_pkg::*;
#(
  parameter int unsigned N_GPIO = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [4:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe
`ifdef GPIO_IRQ_EN
  ,
  output logic              irq
`endif
);

  apb_state_e state_q, state_d;

  // Transfer attributes captured on entry to StAck so the access completes
  // even if the master drops PSEL early.
  logic [4:0]        addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [N_GPIO-1:0] moder_q, moder_d, odr_q, odr_d;
  logic [N_GPIO-1:0] idr, rise, wdata, wmask;
  logic [31:0]       wmask32, rdata;
  logic              ack, err, commit, unused_bits;

  gpio_sync #(
    .Width(N_GPIO)
  ) u_sync (
    .clk_i  (PCLK),
    .rst_ni (PRESET),
    .async_i(gpio_in),
    .sync_o (idr),
    .rise_o (rise)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (PSEL && PENABLE) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && PSEL && PENABLE) begin
        addr_q  <= {PADDR[4:2], 2'b00};
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
    end
  end

  assign ack         = (state_q == StAck);
  assign wmask32     = strb_mask(strb_q);
  assign wmask       = wmask32[N_GPIO-1:0];
  assign wdata       = wdata_q[N_GPIO-1:0];
  assign unused_bits = ^{PADDR[1:0], wdata_q, wmask32};

  always_comb begin
    err = (addr_q > OffIsr) || (write_q && addr_q == OffIdr);
`ifndef GPIO_IRQ_EN
    if (addr_q == OffIer || addr_q == OffIsr) err = 1'b1;
`endif
  end

  assign commit = ack && write_q && !err;

  always_comb begin
    moder_d = moder_q;
    odr_d   = odr_q;
    if (commit && addr_q == OffModer) moder_d = (moder_q & ~wmask) | (wdata & wmask);
    if (commit && addr_q == OffOdr)   odr_d   = (odr_q & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      moder_q <= '0;
      odr_q   <= '0;
    end else begin
      moder_q <= moder_d;
      odr_q   <= odr_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [N_GPIO-1:0] ier_q, ier_d, isr_q, isr_d;

  // Edge set is applied after the W1C clear so a coincident set wins.
  always_comb begin
    ier_d = ier_q;
    isr_d = isr_q;
    if (commit && addr_q == OffIer) ier_d = (ier_q & ~wmask) | (wdata & wmask);
    if (commit && addr_q == OffIsr) isr_d = isr_q & ~(wdata & wmask);
    isr_d = isr_d | (rise & ier_q);
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ier_q <= '0;
      isr_q <= '0;
    end else begin
      ier_q <= ier_d;
      isr_q <= isr_d;
    end
  end

  assign irq = |(isr_q & ier_q);
`else
  logic unused_rise;
  assign unused_rise = ^rise;
`endif

  always_comb begin
    rdata = '0;
    unique case (addr_q)
      OffModer: rdata = 32'(moder_q);
      OffOdr:   rdata = 32'(odr_q);
      OffIdr:   rdata = 32'(idr);
`ifdef GPIO_IRQ_EN
      OffIer:   rdata = 32'(ier_q);
      OffIsr:   rdata = 32'(isr_q);
`endif
      default:  rdata = '0;
    endcase
  end

  assign PREADY   = ack;
  assign PSLVERR  = ack && err;
  assign PRDATA   = (ack && !err) ? rdata : '0;
  assign gpio_out = odr_q;
  assign gpio_oe  = moder_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Scoreboard bench for apb_gpio_slave: directed scenarios then random APB
// traffic against a register-level reference model.
module tb_apb_gpio_slave;

  localparam int unsigned N = 12;
`ifdef GPIO_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [4:0]    PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [N-1:0]  gpio_in, gpio_out, gpio_oe;
`ifdef GPIO_IRQ_EN
  logic          irq;
`endif

  apb_gpio_slave #(
    .N_GPIO(N)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe)
`ifdef GPIO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [32:0]  exp_q[$];
  logic [32:0]  mon_e;
  logic [N-1:0] moder_m, odr_m, idr_m, ier_m, isr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Response monitor: every completed transfer must match the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESET === 1'b1 && PREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pready: got PREADY=1, required no pending access at %0t",
                 $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("prdata", PRDATA, mon_e[31:0]);
        check("pslverr", 32'(PSLVERR), 32'(mon_e[32]));
      end
    end
  end

  function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
    logic [N-1:0] r;
    r = old;
    for (int i = 0; i < N; i++) if (st[i/8]) r[i] = wd[i];
    return r;
  endfunction

  task automatic model_access(input logic [4:0] addr, input logic wr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output logic er);
    int idx;
    bit exists;
    idx    = int'(addr) / 4;
    exists = (idx <= 4) && (IrqEn || idx <= 2);
    er     = !exists || (wr && idx == 2);
    rd     = '0;
    if (!er) begin
      case (idx)
        0: rd = 32'(moder_m);
        1: rd = 32'(odr_m);
        2: rd = 32'(idr_m);
        3: rd = 32'(ier_m);
        default: rd = 32'(isr_m);
      endcase
      if (wr) begin
        case (idx)
          0: moder_m = merge(moder_m, wd, st);
          1: odr_m   = merge(odr_m, wd, st);
          3: ier_m   = merge(ier_m, wd, st);
          4: isr_m   = isr_m & ~merge('0, wd, st);
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    check("gpio_out", 32'(gpio_out), 32'(odr_m));
    check("gpio_oe", 32'(gpio_oe), 32'(moder_m));
`ifdef GPIO_IRQ_EN
    check("irq", 32'(irq), 32'(|(isr_m & ier_m)));
`endif
  endtask

  task automatic apb(input logic [4:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [3:0] st, input bit pin_chg, input logic [N-1:0] pin_val,
                     input bit drop_psel);
    logic [31:0]  rd;
    logic         er;
    logic [N-1:0] old_idr, ier_old;
    @(posedge PCLK); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = st; PSEL = 1'b1; PENABLE = 1'b0;
    old_idr = idr_m;
    ier_old = ier_m;
    if (pin_chg) begin
      gpio_in = pin_val;
      idr_m   = pin_val;
    end
    model_access(addr, wr, wd, st, rd, er);
    isr_m = isr_m | (idr_m & ~old_idr & ier_old);
    exp_q.push_back({er, rd});
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    check("pready_setup", 32'(PREADY), 32'h0);
    @(posedge PCLK); #1;
    check("pready_ack", 32'(PREADY), 32'h1);
    if (drop_psel) begin
      PSEL = 1'b0; PENABLE = 1'b0; PWDATA = ~wd; PADDR = 5'h1C; PWRITE = ~wr;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("pready_done", 32'(PREADY), 32'h0);
    check_outputs();
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    apb(a, 1'b1, d, s, 1'b0, '0, 1'b0);
  endtask

  task automatic rd_reg(input logic [4:0] a);
    apb(a, 1'b0, $urandom, 4'($urandom), 1'b0, '0, 1'b0);
  endtask

  task automatic set_pins(input logic [N-1:0] v);
    logic [N-1:0] old;
    @(posedge PCLK); #1;
    gpio_in = v;
    repeat (3) @(posedge PCLK);
    #1;
    old   = idr_m;
    idr_m = v;
    isr_m = isr_m | (v & ~old & ier_m);
    check_outputs();
  endtask

  task automatic release_reset();
    @(posedge PCLK); #1;
    PRESET  = 1'b1;
    moder_m = '0; odr_m = '0; ier_m = '0; isr_m = '0;
    repeat (3) @(posedge PCLK);
    idr_m = gpio_in;
  endtask

  initial begin
    PRESET = 1'b1;
    PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0;
    gpio_in = '0;
    moder_m = '0; odr_m = '0; idr_m = '0; ier_m = '0; isr_m = '0;
    #1 PRESET = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(PREADY), 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check_outputs();
    release_reset();

    // Output-enable write through lane 0, then strobe gating of ODR.
    wr_reg(5'h00, 32'h0000_000F, 4'h1);
    wr_reg(5'h04, 32'h0000_00AA, 4'h0);
    wr_reg(5'h04, 32'h0000_00AA, 4'h1);
    wr_reg(5'h04, 32'hFFFF_F355, 4'h2);
    rd_reg(5'h04);

    // Synchronized input read, IDR write rejected, 2-edge latency.
    set_pins(12'h05A);
    rd_reg(5'h08);
    wr_reg(5'h08, 32'h0000_0FFF, 4'hF);
    rd_reg(5'h0B);
    apb(5'h08, 1'b0, 32'h0, 4'h0, 1'b1, 12'h3C1, 1'b0);

    // Unmapped and interrupt-register addresses.
    rd_reg(5'h1C);
    wr_reg(5'h14, 32'hFFFF_FFFF, 4'hF);
    rd_reg(5'h0C);
    rd_reg(5'h10);

    // Master drops PSEL in the wait state; access still completes.
    apb(5'h04, 1'b1, 32'h0000_0123, 4'h3, 1'b0, '0, 1'b1);

`ifdef GPIO_IRQ_EN
    set_pins('0);
    wr_reg(5'h0C, 32'h0000_0001, 4'h1);
    set_pins(12'h001);
    rd_reg(5'h10);
    wr_reg(5'h10, 32'h0000_0001, 4'h1);
    rd_reg(5'h10);
    set_pins('0);
    apb(5'h10, 1'b1, 32'h0000_0001, 4'h1, 1'b1, 12'h001, 1'b0);
    rd_reg(5'h10);
`endif

    // Reset asserted in the wait state aborts the write.
    @(posedge PCLK); #1;
    PADDR = 5'h04; PWRITE = 1'b1; PWDATA = 32'h0000_0FFF; PSTRB = 4'hF; PSEL = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("pready_pre_reset", 32'(PREADY), 32'h1);
    PRESET = 1'b0;
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    moder_m = '0; odr_m = '0; ier_m = '0; isr_m = '0;
    check("abort_pready", 32'(PREADY), 32'h0);
    check("abort_pslverr", 32'(PSLVERR), 32'h0);
    check("abort_prdata", PRDATA, 32'h0);
    check_outputs();
    release_reset();
    wr_reg(5'h04, 32'h0000_0033, 4'h1);
    rd_reg(5'h04);

    for (int i = 0; i < 120; i++) begin
      logic [4:0] a;
      if ($urandom_range(0, 9) == 0) begin
        set_pins(N'($urandom));
      end else begin
        if ($urandom_range(0, 9) < 8) a = {3'($urandom_range(0, 4)), 2'($urandom_range(0, 3))};
        else a = 5'($urandom_range(0, 31));
        apb(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 7) == 0, N'($urandom),
            $urandom_range(0, 7) == 0);
      end
    end

    repeat (2) @(posedge PCLK);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
